// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the WISC decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_stage_if;
   logic [15:0] instr_i;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] instr_o;
   logic [3:0]  rd_addr;
   logic [3:0]  p0_addr;
   logic [3:0]  p1_addr;
   logic [7:0]  imm;
   logic        src_sel;
   logic [2:0]  alu_op;
   logic        we_rf;
   logic        mem_re;
   logic        mem_we;
   logic        ctrl;
   logic        halt;

   modport slave (
      input  instr_i, in_valid, flush, out_ready,
      output in_ready, out_valid, instr_o, rd_addr, p0_addr, p1_addr, imm,
             src_sel, alu_op, we_rf, mem_re, mem_we, ctrl, halt
   );

   modport master (
      output instr_i, in_valid, flush, out_ready,
      input  in_ready, out_valid, instr_o, rd_addr, p0_addr, p1_addr, imm,
             src_sel, alu_op, we_rf, mem_re, mem_we, ctrl, halt
   );
endinterface

// File: rtl/decode_stage.sv
// WISC decode stage: one register slice between fetch and execute that decodes
// the 16-bit instruction into register addresses, immediate and control strobes.
// Halt is sticky once an HLT is accepted; flush kills held and incoming work.
module decode_stage (
   input  logic           clk,
   input  logic           rst_n,
   decode_stage_if.slave  bus
);

   typedef struct packed {
      logic [15:0] instr;
      logic [3:0]  rd;
      logic [3:0]  p0;
      logic [3:0]  p1;
      logic [7:0]  imm;
      logic        src_sel;
      logic [2:0]  alu_op;
      logic        we_rf;
      logic        mem_re;
      logic        mem_we;
      logic        ctrl;
   } fields_t;

   fields_t    dec;
   fields_t    fields_q, fields_d;
   logic       out_valid_q, out_valid_d;
   logic       halted_q, halted_d;
   logic       accept;
   logic [3:0] opcode;

   // Sign-extend the 4-bit LW/SW offset to the 8-bit immediate.
   function automatic logic [7:0] sext4(input logic [3:0] v);
      return {{4{v[3]}}, v};
   endfunction

   assign opcode = bus.instr_i[15:12];

   // Ready is forced low while in reset so nothing is offered as accepted.
   assign bus.in_ready = rst_n && !halted_q && !bus.flush && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // Decode the incoming instruction; unlisted control fields stay 0.
   always_comb begin
      dec        = '0;
      dec.instr  = bus.instr_i;
      dec.rd     = bus.instr_i[11:8];
      dec.p0     = bus.instr_i[7:4];
      dec.p1     = bus.instr_i[3:0];
      dec.alu_op = opcode[3] ? 3'b000 : opcode[2:0];
      case (opcode)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
            dec.src_sel = 1'b1;
            dec.we_rf   = 1'b1;
         end
         4'h5, 4'h6, 4'h7: begin
            dec.imm   = {4'b0000, bus.instr_i[3:0]};
            dec.we_rf = 1'b1;
         end
         4'h8: begin
            dec.imm    = sext4(bus.instr_i[3:0]);
            dec.mem_re = 1'b1;
            dec.we_rf  = 1'b1;
         end
         4'h9: begin
            // Store data register is encoded in the rd slot.
            dec.imm    = sext4(bus.instr_i[3:0]);
            dec.p1     = bus.instr_i[11:8];
            dec.mem_we = 1'b1;
         end
         4'hA: begin
            // LHB reads the destination so execute can keep its low byte.
            dec.p0    = bus.instr_i[11:8];
            dec.imm   = bus.instr_i[7:0];
            dec.we_rf = 1'b1;
         end
         4'hB: begin
            dec.imm   = bus.instr_i[7:0];
            dec.we_rf = 1'b1;
         end
         4'hC, 4'hE: begin
            dec.ctrl    = 1'b1;
            dec.src_sel = 1'b1;
         end
         4'hD: begin
            // JAL links into R15.
            dec.ctrl  = 1'b1;
            dec.we_rf = 1'b1;
            dec.rd    = 4'hF;
         end
         default: ;
      endcase
   end

   // Next-state for the output slice: flush wins, then accept, then drain.
   always_comb begin
      fields_d    = accept ? dec : fields_q;
      out_valid_d = out_valid_q;
      if (bus.flush)
         out_valid_d = 1'b0;
      else if (accept)
         out_valid_d = 1'b1;
      else if (bus.out_ready)
         out_valid_d = 1'b0;
      halted_d = halted_q || (accept && (opcode == 4'hF));
   end

   // State registers; reset clears everything immediately, even mid-stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fields_q    <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         fields_q    <= fields_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.halt      = halted_q;
   assign bus.instr_o   = fields_q.instr;
   assign bus.rd_addr   = fields_q.rd;
   assign bus.p0_addr   = fields_q.p0;
   assign bus.p1_addr   = fields_q.p1;
   assign bus.imm       = fields_q.imm;
   assign bus.src_sel   = fields_q.src_sel;
   assign bus.alu_op    = fields_q.alu_op;
   assign bus.we_rf     = fields_q.we_rf;
   assign bus.mem_re    = fields_q.mem_re;
   assign bus.mem_we    = fields_q.mem_we;
   assign bus.ctrl      = fields_q.ctrl;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction decode stage for the WISC core. Accepts 16-bit instructions from fetch over a valid/ready handshake and registers the decoded fields for execute. Outputs include register-file read addresses, the 8-bit immediate and the ALU source select consumed by the execute-stage source mux (sel=1 picks register p1, sel=0 picks the sign-extended imm). Also generates write-enable, memory and halt control, with support for stall, flush and halt.

## Interface
- No parameters; all widths are fixed by the ISA (16-bit instruction, 4-bit register address, 8-bit immediate).
- clk  input  1  Clock; all state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- instr_i  input  16  Instruction from fetch.
- in_valid  input  1  instr_i is valid.
- in_ready  output  1  Stage can accept an instruction this cycle.
- flush  input  1  Kill the held instruction and any incoming one.
- out_valid  output  1  Decoded outputs are valid.
- out_ready  input  1  Execute consumes the outputs this cycle.
- instr_o  output  16  Registered raw instruction, for branch/jump logic.
- rd_addr  output  4  Destination register.
- p0_addr  output  4  Read port 0 address.
- p1_addr  output  4  Read port 1 address.
- imm  output  8  Immediate, pre-sign-extension.
- src_sel  output  1  1 = ALU src1 from p1, 0 = from imm.
- alu_op  output  3  Equal to opcode[2:0] for opcodes 0000–0111, else 000.
- we_rf  output  1  Register write enable.
- mem_re, mem_we  output  1 each  Load and store strobes.
- ctrl  output  1  Opcode is 1100–1110 (B/JAL/JR).
- halt  output  1  Sticky: HLT accepted.

## Operation
- Opcode is instr[15:12]. Default field extraction: rd=instr[11:8], p0=instr[7:4], p1=instr[3:0].
- 0000–0100 (ADD, ADDZ, SUB, AND, NOR): src_sel=1, we_rf=1, imm=0.
- 0101–0111 (SLL, SRL, SRA): imm={4'b0,instr[3:0]}, src_sel=0, we_rf=1.
- 1000 LW: imm = sign-extension of instr[3:0] to 8 bits, src_sel=0, mem_re=1, we_rf=1.
- 1001 SW: as LW for imm/src_sel; p1=instr[11:8] (store data); mem_we=1, we_rf=0.
- 1010 LHB: p0=instr[11:8], imm=instr[7:0], src_sel=0, we_rf=1.
- 1011 LLB: imm=instr[7:0], src_sel=0, we_rf=1. Downstream sign-extension is the required LLB semantics.
- 1100 B / 1110 JR: ctrl=1, we_rf=0, src_sel=1.
- 1101 JAL: ctrl=1, we_rf=1, rd=4'hF.
- 1111 HLT: all enables 0. When accepted, halt and an internal halted flag set and stay set until reset.
- Control fields not listed for an opcode are 0.
- in_ready = !halted && !flush && (!out_valid || out_ready).
- Accept (in_valid && in_ready): all output registers load the decoded values; out_valid=1.
- out_valid && out_ready with no accept: out_valid→0. Data registers hold their values.
- Stall (out_valid && !out_ready): all outputs hold stable, in_ready=0.
- flush: next edge out_valid=0. Any same-cycle input is not accepted. flush has priority over everything except reset.
- Decoded outputs other than halt are meaningful only while out_valid=1.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle while out_ready=1.
- Reset (asynchronous, rst_n low): out_valid=0, in_ready=0 while rst_n low, every data/control output 0, halt=0, halted=0.
- First accept is possible on the first edge after rst_n deasserts.
- Reset mid-stall clears the held instruction immediately, without waiting for an edge.
- HLT while stalled: halt rises only on the edge the HLT is accepted. Older instructions already held still drain normally.
- After halt, in_ready stays 0 regardless of out_ready.
- flush and out_ready in the same cycle: out_valid→0, no new accept.

## Test plan
- Accept 0x0312 (ADD R3,R1,R2) → next cycle out_valid=1, rd=3, p0=1, p1=2, src_sel=1, we_rf=1, alu_op=000.
- Back-to-back 0x5457, 0x826E, 0xB180 → imm 0x07 (src_sel=0, alu_op=101); then 0xFE with mem_re=1; then 0x80 with we_rf=1.
- Hold out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. Release → stream continues with no loss or duplication.
- flush while holding 0x9123 and in_valid=1 → out_valid=0 next cycle; neither instruction appears at the output.
- Accept 0xF000 → halt=1, in_ready=0. Further in_valid is ignored until rst_n pulses, after which halt=0.
- Assert rst_n=0 asynchronously mid-stall → out_valid and all outputs 0 before the next clock edge.
